// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive front end.
//   rx_state_t     : receiver FSM state encoding
//   PRESCALE_*     : legal oversampling ratios
//   PAR_EVEN/ODD   : parity-type select values
//   majority3      : 2-of-3 vote used on the mid-bit samples
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_t;

    localparam int PRESCALE_8  = 8;
    localparam int PRESCALE_16 = 16;
    localparam int PRESCALE_32 = 32;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    function automatic logic majority3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit timing and sampling for the UART receiver.
// Ports:
//   clk, rst_n   : oversampling clock, async active-low reset
//   start        : start-detection cycle; latches the prescale for the frame
//   run          : a frame is in progress (edge counter advances)
//   rx           : serial line, already synchronous to clk
//   prescale     : raw oversampling ratio; anything but 8/16/32 means 8
//   bit_val      : majority of the three mid-bit samples
//   sample_done  : bit_val has just become valid for the current bit
//   bit_done     : last oversampling cycle of the current bit
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      run,
    input  logic                      rx,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic                      bit_val,
    output logic                      sample_done,
    output logic                      bit_done
);

    localparam logic [PRESCALE_WIDTH-1:0] P8  = PRESCALE_WIDTH'(PRESCALE_8);
    localparam logic [PRESCALE_WIDTH-1:0] P16 = PRESCALE_WIDTH'(PRESCALE_16);
    localparam logic [PRESCALE_WIDTH-1:0] P32 = PRESCALE_WIDTH'(PRESCALE_32);
    localparam logic [PRESCALE_WIDTH-1:0] ONE = PRESCALE_WIDTH'(1);
    localparam logic [PRESCALE_WIDTH-1:0] TWO = PRESCALE_WIDTH'(2);

    logic [PRESCALE_WIDTH-1:0] prescale_q;
    logic [PRESCALE_WIDTH-1:0] prescale_eff;
    logic [PRESCALE_WIDTH-1:0] half;
    logic [PRESCALE_WIDTH-1:0] edge_cnt;
    logic [2:0]                samples;

    // In the detection cycle the latched value is not yet updated, so the
    // live (normalised) input is used for that single cycle.
    always_comb begin
        prescale_eff = prescale_q;
        if (start) begin
            prescale_eff = (prescale == P16 || prescale == P32) ? prescale : P8;
        end
        half = prescale_eff >> 1;
    end

    assign bit_done    = run && (edge_cnt == prescale_eff - ONE);
    assign sample_done = run && (edge_cnt == half + TWO);
    assign bit_val     = majority3(samples);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescale_q <= P8;
        end else if (start) begin
            prescale_q <= prescale_eff;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_cnt <= '0;
        end else if (!run || bit_done) begin
            edge_cnt <= '0;
        end else begin
            edge_cnt <= edge_cnt + ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samples <= 3'b111;
        end else if (run) begin
            if (edge_cnt == half - ONE) samples[0] <= rx;
            if (edge_cnt == half)       samples[1] <= rx;
            if (edge_cnt == half + ONE) samples[2] <= rx;
        end
    end

endmodule

// File: rtl/uart_rx_frontend.sv
// Oversampling UART receiver: deserialises RX_IN into bytes, checks optional
// parity and the stop bit, and reports one pulse per completed frame.
// Ports:
//   CLK, RST       : oversampling clock, async active-low reset
//   RX_IN          : serial line, idle high
//   Prescale       : oversampling ratio (8/16/32, others treated as 8)
//   PAR_EN/PAR_TYP : parity present / odd parity
//   P_DATA         : last correctly received byte
//   data_valid     : one-cycle pulse, P_DATA updated
//   parity_error   : one-cycle pulse, parity mismatch
//   framing_error  : one-cycle pulse, stop bit sampled 0
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | line idle; RX_IN=0 here is edge 0 of the start bit
// ST_START  | start bit; voted 1 is a glitch, back to idle at bit end
// ST_DATA   | payload bits shifted in LSB first
// ST_PARITY | parity bit compared against the payload
// ST_STOP   | stop bit; frame result registered at bit end
module uart_rx_frontend
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      RX_IN,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    output logic [DATA_WIDTH-1:0]     P_DATA,
    output logic                      data_valid,
    output logic                      parity_error,
    output logic                      framing_error
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    rx_state_t state, state_next;

    logic                  start;
    logic                  run;
    logic                  bit_val;
    logic                  sample_done;
    logic                  bit_done;
    logic [CNT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic                  par_err;
    logic                  parity_exp;

    assign start = (state == ST_IDLE) && !RX_IN;
    assign run   = start || (state != ST_IDLE);

    assign parity_exp = (^shift_reg) ^ (par_typ_q == PAR_ODD);

    uart_rx_sampler #(
        .PRESCALE_WIDTH (PRESCALE_WIDTH)
    ) u_sampler (
        .clk         (CLK),
        .rst_n       (RST),
        .start       (start),
        .run         (run),
        .rx          (RX_IN),
        .prescale    (Prescale),
        .bit_val     (bit_val),
        .sample_done (sample_done),
        .bit_done    (bit_done)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (!RX_IN) state_next = ST_START;
            end
            ST_START: begin
                if (bit_done) state_next = bit_val ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                // bit_cnt is bumped at sample_done, so it already counts
                // the current bit by the time bit_done arrives.
                if (bit_done && bit_cnt == LAST_BIT) begin
                    state_next = par_en_q ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (bit_done) state_next = ST_STOP;
            end
            ST_STOP: begin
                if (bit_done) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            bit_cnt       <= '0;
            shift_reg     <= '0;
            par_en_q      <= 1'b0;
            par_typ_q     <= 1'b0;
            par_err       <= 1'b0;
            P_DATA        <= '0;
            data_valid    <= 1'b0;
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            data_valid    <= 1'b0;
            parity_error  <= 1'b0;
            framing_error <= 1'b0;

            if (start) begin
                par_en_q  <= PAR_EN;
                par_typ_q <= PAR_TYP;
                bit_cnt   <= '0;
                par_err   <= 1'b0;
            end

            if (state == ST_DATA && sample_done) begin
                shift_reg <= {bit_val, shift_reg[DATA_WIDTH-1:1]};
                bit_cnt   <= bit_cnt + CNT_ONE;
            end

            if (state == ST_PARITY && sample_done) begin
                par_err <= (bit_val != parity_exp);
            end

            if (state == ST_STOP && bit_done) begin
                if (!bit_val) begin
                    framing_error <= 1'b1;
                end else if (par_err) begin
                    parity_error <= 1'b1;
                end else begin
                    data_valid <= 1'b1;
                    P_DATA     <= shift_reg;
                end
            end
        end
    end

endmodule

// File: doc/uart_rx_frontend.md
Name: uart_rx_frontend

Overview:
Oversampling UART receiver that deserialises the RX line into bytes and hands them to the system controller's command decoder. It sits in the UART clock domain, directly upstream of the RX data synchroniser that produces RX_P_DATA/RX_D_VLD for the controller. It handles start-glitch rejection, majority-vote sampling, optional parity and stop-bit checking, and reports a one-cycle valid or error pulse per frame.

Parameters:
DATA_WIDTH, 8, payload bits per frame (LSB first)
PRESCALE_WIDTH, 6, width of Prescale input

Ports:
CLK  in  1  UART oversampling clock
RST  in  1  asynchronous active-low reset
RX_IN  in  1  serial line, idle high; already synchronous to CLK
Prescale  in  PRESCALE_WIDTH  oversampling ratio P; legal 8, 16, 32
PAR_EN  in  1  1 = parity bit present
PAR_TYP  in  1  0 = even, 1 = odd
P_DATA  out  DATA_WIDTH  last correctly received byte
data_valid  out  1  one-cycle pulse, P_DATA updated
parity_error  out  1  one-cycle pulse, parity mismatch
framing_error  out  1  one-cycle pulse, stop bit sampled 0

Behaviour:
- One clock, CLK; reset RST is asynchronous and active-low. On reset: state IDLE, all counters 0, P_DATA=0, data_valid=0, parity_error=0, framing_error=0. Reset mid-frame aborts the frame with no pulses.
- Prescale, PAR_EN and PAR_TYP are latched in the start-detection cycle and held for the frame. A Prescale value other than 8/16/32 is treated as 8.
- edge_cnt runs 0..P-1 within each bit. The IDLE cycle that sees RX_IN=0 is edge_cnt=0 of the start bit.
- Sampling: RX_IN is captured at edge_cnt = P/2-1, P/2 and P/2+1. The bit value is the majority of the three samples, valid from edge_cnt = P/2+2. The bit ends at edge_cnt = P-1.
- States:
  - IDLE: on RX_IN=0 go to START.
  - START: if the voted start bit is 1, treat it as a glitch and return to IDLE at the end of the bit with no pulses. Otherwise go to DATA at end of bit.
  - DATA: shift the voted bit into the shift register LSB first. After DATA_WIDTH bits go to PARITY if PAR_EN, else STOP.
  - PARITY: compare the voted bit with the computed parity (even: XOR of data; odd: inverted XOR). Record any mismatch. Go to STOP.
  - STOP: at edge_cnt=P-1 go to IDLE and register the frame result.
- Result, in the cycle after the last stop-bit cycle (exactly one cycle wide):
  - Stop bit 0: framing_error=1 (takes precedence).
  - Else parity mismatch: parity_error=1.
  - Else data_valid=1 and P_DATA is loaded with the shift register.
  - On any error P_DATA keeps its old value.
- Latency: with F = 1 + DATA_WIDTH + PAR_EN + 1 bits, the pulse is high in cycle F*P counted from the detection cycle (cycle 0).
- Back-to-back frames: the result cycle coincides with IDLE. A start bit beginning in that cycle is detected normally, so zero idle bits between frames are supported.
- Line held low forever: a framing_error pulse occurs each frame period, with no lockup.

Decomposition:
- Shared package uart_pkg holds:
  - the state encoding (IDLE, START, DATA, PARITY, STOP)
  - legal prescale constants PRESCALE_8/16/32
  - parity-type constants PAR_EVEN=0, PAR_ODD=1
- One sub-module, uart_rx_sampler, contains the edge counter, the three-sample capture, the majority vote, and the sample_done/bit_done strobes.
- Top level holds the FSM, bit counter, shift register, parity check and output registers.

Test Plan:
- P=8, PAR_EN=0, send 0xA5 with one stop bit -> data_valid high in cycle 80 only, P_DATA=0xA5, no errors.
- P=16, PAR_EN=1, PAR_TYP=0, send 0x3C with parity 0 -> data_valid in cycle 176, P_DATA=0x3C. Repeat with parity 1 -> parity_error pulse, P_DATA still 0x3C.
- P=32, PAR_EN=0, send 0x81 with stop bit 0 -> framing_error pulse in cycle 320, data_valid=0, P_DATA unchanged.
- P=8, RX_IN low for 3 cycles then high -> return to IDLE, no pulses. A following frame 0x5A is received correctly.
- P=8, one-cycle low glitch at edge_cnt=P/2 inside bit 3 of 0xFF -> majority vote keeps bit=1, P_DATA=0xFF. Back-to-back frames 0x12, 0x34 with zero gap -> two data_valid pulses 80 cycles apart.
- Assert RST during DATA of 0x77, release, then send 0x66 -> outputs 0 during reset, no pulse for the aborted frame, then data_valid with P_DATA=0x66.
